// File: rtl/div_pkg.sv
// div_pkg: state encoding and constants shared by the divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DIV_ITER = 32;
  localparam int CNT_W = 5;
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration producing a quotient bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pr,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] pr_next,
  output logic             q_bit
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {pr, dvd_msb};
    diff = sh - {1'b0, dvs};
    q_bit = ~diff[WIDTH];
    pr_next = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/div_core.sv
// div_core: multi-cycle radix-2 restoring divider returning {remainder, quotient}
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cancel,
  input  logic               sign_en,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  output logic               busy,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pr, dvd, dvs, raw, pr_n, quo, rem;
  logic sgn, neg_a, neg_b, q_bit, go;
  div_step #(.WIDTH(WIDTH)) u_step (
    .pr(pr),
    .dvd_msb(dvd[WIDTH-1]),
    .dvs(dvs),
    .pr_next(pr_n),
    .q_bit(q_bit)
  );
  assign go = state == IDLE && start && !cancel;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = cancel ? IDLE :
              state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (cnt == CNT_W'(DIV_ITER - 1) ? FIX : CALC) :
              state == FIX ? DONE : IDLE;
    quo = sgn && (neg_a ^ neg_b) ? -dvd : dvd;
    rem = sgn && neg_a ? -pr : pr;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pr <= '0;
      dvd <= '0;
      dvs <= '0;
      raw <= '0;
      sgn <= 1'b0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      out <= '0;
    end else if (go) begin
      sgn <= sign_en;
      raw <= op1;
      neg_a <= op1[WIDTH-1];
      neg_b <= op2[WIDTH-1];
      dvd <= sign_en && op1[WIDTH-1] ? -op1 : op1;
      dvs <= sign_en && op2[WIDTH-1] ? -op2 : op2;
      cnt <= '0;
      pr <= '0;
    end else if (state == CALC) begin
      pr <= pr_n;
      dvd <= {dvd[WIDTH-2:0], q_bit};
      cnt <= cnt + 1'b1;
    end else if (state == FIX && !cancel) begin
      out <= dvs == '0 ? {raw, DIV0_QUO} : {rem, quo};
    end
  end
endmodule

// File: tb/tb_div_core.sv
// tb_div_core: scoreboard bench for div_core with directed vectors
module tb_div_core;
  logic clk = 1'b0;
  logic rst, start, cancel, sign_en, busy, out_valid;
  logic [31:0] op1, op2;
  logic [63:0] out;
  logic [63:0] exp_q[$];
  int cyc = 0;
  int acc = 0;
  int checks = 0;
  int errors = 0;

  div_core #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cancel(cancel),
    .sign_en(sign_en),
    .op1(op1),
    .op2(op2),
    .busy(busy),
    .out_valid(out_valid),
    .out(out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got out_valid=1 with out=%h expected no result", out);
        end else begin
          e = exp_q.pop_front();
          check("result", out, e);
          check("latency", 64'(cyc - acc), 64'd33);
        end
      end
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    sign_en = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc = cyc;
  endtask

  task automatic finish_op();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 80) break;
      n++;
    end
    check("busy_span", 64'(cyc - acc), 64'd34);
    check("drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    exp_q.push_back(e);
    issue(s, a, b);
    finish_op();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    sign_en = 1'b0;
    op1 = '0;
    op2 = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", out, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    run(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
    run(1'b1, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    run(1'b0, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
    run(1'b1, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
    run(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    run(1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001);
    run(1'b0, 32'd5, 32'd9, 64'h00000005_00000000);

    issue(1'b0, 32'd999, 32'd3);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_valid", {63'd0, out_valid}, 64'd0);
    check("cancel_out", out, 64'h00000005_00000000);
    #1;
    run(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064);

    exp_q.push_back(64'h00000078_00123456);
    issue(1'b0, 32'h12345678, 32'h100);
    repeat (3) @(posedge clk);
    #1 begin
      sign_en = 1'b1;
      op1 = 32'd1;
      op2 = 32'd1;
      start = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    finish_op();

    issue(1'b1, 32'd77, 32'd5);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out", out, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rst_quiet_out", out, 64'd0);
    #1;
    run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
